// File: rtl/pram_pkg.sv
// Shared PRAM definitions: loader state encoding, default widths, PRAM depth.
// Imported by the loader, its interface and anything modelling the PRAM.
package pram_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int PRAM_DEPTH = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    LOAD,
    CHK,
    FIN
  } state_t;

endpackage

// File: rtl/pram_loader_if.sv
// Host byte stream + PRAM write port + status of the PRAM loader.
// slave: loader side; master: host/PRAM side.
interface pram_loader_if
  import pram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wr_addr, wr_data, wr_en,
    output busy, done, error
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, wr_addr, wr_data, wr_en,
    input  busy, done, error
  );

endinterface

// File: rtl/pram_loader_csum.sv
// 8-bit modular sum of loaded bytes with clear, add and compare.
// Ports: clk/reset, clr, add, din (byte to add), cmp (byte to compare), match.
module pram_loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  input  logic [7:0] cmp,
  output logic       match
);

  logic [7:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + din;
    end
  end

  assign match = (sum == cmp);

endmodule

// File: rtl/pram_loader.sv
// PRAM loader: takes a 16-bit length (LSB first) then N bytes, writes PRAM.
// Ports: clk, reset (async high), bus (pram_loader_if.slave).
// Option: PRAM_LOADER_CHECKSUM_EN adds a trailing 8-bit sum byte check.
module pram_loader
  import pram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic clk,
  input  logic reset,
  pram_loader_if.slave bus
);

  // Largest length that fits the address space without aliasing.
  localparam logic [31:0] MAX_N =
    (ADDR_W >= 16) ? 32'h0001_0000 : (32'd1 << ADDR_W);

  state_t            state;
  logic [15:0]       len;
  logic [15:0]       idx;
  logic [ADDR_W-1:0] addr_nx;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              done;
  logic              error;
  logic              in_ready;
  logic              xfer;
  logic [15:0]       len_n;
  logic              too_long;

  assign in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == LOAD) || (state == CHK);
  assign xfer     = bus.in_valid & in_ready;
  assign len_n    = {bus.in_data, len[7:0]};
  assign too_long = {16'h0, len_n} > MAX_N;

`ifdef PRAM_LOADER_CHECKSUM_EN
  logic csum_ok;

  pram_loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == IDLE) & bus.start),
    .add   ((state == LOAD) & xfer),
    .din   (bus.in_data),
    .cmp   (bus.in_data),
    .match (csum_ok)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      len     <= '0;
      idx     <= '0;
      addr_nx <= BASE_ADDR;
      wr_addr <= BASE_ADDR;
      wr_data <= '0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= LEN_LO;
            error   <= 1'b0;
            idx     <= '0;
            len     <= '0;
            addr_nx <= BASE_ADDR;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.in_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= bus.in_data;
            if (len_n == 16'h0) begin
              state <= FIN;
            end else if (too_long) begin
              error <= 1'b1;
              state <= FIN;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_nx;
            wr_data <= DATA_W'(bus.in_data);
            addr_nx <= addr_nx + 1'b1;
            idx     <= idx + 16'd1;
            if (idx == len - 16'd1) begin
`ifdef PRAM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= FIN;
`endif
            end
          end
        end
        CHK: begin
`ifdef PRAM_LOADER_CHECKSUM_EN
          if (xfer) begin
            if (!csum_ok) error <= 1'b1;
            state <= FIN;
          end
`else
          state <= FIN;
`endif
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.wr_en    = wr_en;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.error    = error;

endmodule

// File: tb/tb_pram_loader.sv
// Directed bench for pram_loader: table of load vectors plus
// hand sequences for zero length, reset mid-load and address wrap.
module tb_pram_loader;

  logic       clk;
  logic       reset;
  logic       start0;
  logic       start1;
  logic [7:0] in_data;
  logic       in_valid;

  int total = 0;
  int bad   = 0;

  pram_loader_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();
  pram_loader_if #(.ADDR_W(16), .DATA_W(8)) bus1 ();

  assign bus0.start    = start0;
  assign bus0.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus1.start    = start1;
  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;

  pram_loader #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'h0000)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  pram_loader #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'hFFFE)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] wq0[$];
  logic [23:0] wq1[$];
  int dn0 = 0;
  int dn1 = 0;

  always @(negedge clk) begin
    if (bus0.wr_en) wq0.push_back({bus0.wr_addr, bus0.wr_data});
    if (bus1.wr_en) wq1.push_back({bus1.wr_addr, bus1.wr_data});
    if (bus0.done) dn0++;
    if (bus1.done) dn1++;
  end

  typedef struct {
    int          n;
    logic [63:0] d;
    logic [7:0]  ck;
    bit          eck;
    bit          tog;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int s);
    return (s != 0) ? bus1.in_ready : bus0.in_ready;
  endfunction

  function automatic logic busy_of(input int s);
    return (s != 0) ? bus1.busy : bus0.busy;
  endfunction

  function automatic logic err_of(input int s);
    return (s != 0) ? bus1.error : bus0.error;
  endfunction

  function automatic int wsz(input int s);
    return (s != 0) ? wq1.size() : wq0.size();
  endfunction

  function automatic logic [23:0] wget(input int s, input int i);
    return (s != 0) ? wq1[i] : wq0[i];
  endfunction

  function automatic int dn_of(input int s);
    return (s != 0) ? dn1 : dn0;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) start1 = v;
    else start0 = v;
  endtask

  task automatic pulse_start(input int s);
    @(negedge clk);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
  endtask

  // Offer one byte until accepted; tog randomly drops valid and
  // pulses start during the attempt.
  task automatic push(input logic [7:0] b, input bit tog, input int s);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 200) begin
      @(negedge clk);
      g++;
      if (tog && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      if (tog) set_start(s, 1'($urandom_range(0, 1)));
      acc = in_valid && rdy_of(s);
      @(posedge clk);
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic quiet();
    @(negedge clk);
    in_valid = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int s, input string nm);
    int w;
    int d;
    int g;
    logic [15:0] base;
    logic [15:0] ea;
    bit exp_err;
    w = wsz(s);
    d = dn_of(s);
    base = (s != 0) ? 16'hFFFE : 16'h0000;
`ifdef PRAM_LOADER_CHECKSUM_EN
    exp_err = v.eck;
`else
    exp_err = 1'b0;
`endif
    pulse_start(s);
    push(8'(v.n), v.tog, s);
    push(8'(v.n >> 8), v.tog, s);
    for (int k = 0; k < v.n; k++) push(v.d[8*k +: 8], v.tog, s);
`ifdef PRAM_LOADER_CHECKSUM_EN
    push(v.ck, v.tog, s);
`endif
    quiet();
    g = 0;
    while (busy_of(s) && g < 30) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy_of(s)), 32'd0);
    chk({nm, "_nwr"}, 32'(wsz(s) - w), 32'(v.n));
    for (int k = 0; k < v.n && k < wsz(s) - w; k++) begin
      ea = base + 16'(k);
      chk({nm, "_wr"}, 32'(wget(s, w + k)), {8'h0, ea, v.d[8*k +: 8]});
    end
    chk({nm, "_done"}, 32'(dn_of(s) - d), 32'd1);
    chk({nm, "_err"}, 32'(err_of(s)), 32'(exp_err));
    chk({nm, "_rdy"}, 32'(rdy_of(s)), 32'd0);
  endtask

  vec_t vt[7];
  vec_t vw;

  initial begin
    int w;
    int d;
    vt[0] = '{3, 64'h0000_0000_00CC_BBAA, 8'h31, 1'b0, 1'b0};
    vt[1] = '{2, 64'h0000_0000_0000_2010, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1, 64'h0000_0000_0000_005A, 8'h5A, 1'b0, 1'b0};
    vt[3] = '{4, 64'h0000_0000_FFFF_FFFF, 8'hFC, 1'b0, 1'b0};
    vt[4] = '{3, 64'h0000_0000_0003_0201, 8'h07, 1'b1, 1'b1};
    vt[5] = '{6, 64'h0000_6655_4433_2211, 8'h65, 1'b0, 1'b1};
    vt[6] = '{8, 64'h0807_0605_0403_0201, 8'h24, 1'b0, 1'b1};
    vw    = '{3, 64'h0000_0000_0003_0201, 8'h06, 1'b0, 1'b0};

    reset = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(bus0.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus0.wr_en), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_err", 32'(bus0.error), 32'd0);
    chk("rst_addr0", 32'(bus0.wr_addr), 32'h0000);
    chk("rst_addr1", 32'(bus1.wr_addr), 32'hFFFE);
    chk("rst_data", 32'(bus0.wr_data), 32'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i], 0, $sformatf("vec%0d", i));
    end

    // zero length: no writes, no checksum byte, done two cycles later
    w = wsz(0);
    d = dn_of(0);
    pulse_start(0);
    push(8'h00, 1'b0, 0);
    push(8'h00, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("z_done_early", 32'(bus0.done), 32'd0);
    chk("z_busy", 32'(bus0.busy), 32'd1);
    chk("z_rdy", 32'(bus0.in_ready), 32'd0);
    @(negedge clk);
    chk("z_done", 32'(bus0.done), 32'd1);
    @(negedge clk);
    chk("z_done_off", 32'(bus0.done), 32'd0);
    chk("z_idle", 32'(bus0.busy), 32'd0);
    chk("z_nwr", 32'(wsz(0) - w), 32'd0);
    chk("z_npulse", 32'(dn_of(0) - d), 32'd1);

    // reset right after the second data byte of a 5-byte load
    w = wsz(0);
    pulse_start(0);
    push(8'h05, 1'b0, 0);
    push(8'h00, 1'b0, 0);
    push(8'h11, 1'b0, 0);
    push(8'h22, 1'b0, 0);
    #1 reset = 1'b1;
    #1;
    chk("r_wr_en", 32'(bus0.wr_en), 32'd0);
    chk("r_busy", 32'(bus0.busy), 32'd0);
    chk("r_rdy", 32'(bus0.in_ready), 32'd0);
    chk("r_err", 32'(bus0.error), 32'd0);
    chk("r_addr", 32'(bus0.wr_addr), 32'h0000);
    chk("r_data", 32'(bus0.wr_data), 32'h00);
    in_valid = 1'b1;
    in_data = 8'h33;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("r_nwr", 32'(wsz(0) - w), 32'd1);
    if (wsz(0) > w) chk("r_wr0", 32'(wget(0, w)), 32'h00_0011);
    chk("r_idle", 32'(bus0.busy), 32'd0);
    run_vec(vt[0], 0, "restart");

    // address wrap on the high-base instance
    run_vec(vw, 1, "wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pram_loader.md
PRAM_LOADER -- requirements
Module: pram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, PRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, PRAM data width; length and checksum bytes are always 8 bits.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first PRAM address written.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port in_data  input  8  byte stream from host link.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts byte; transfer = in_valid & in_ready.
REQ-010 SHALL have port wr_addr  output  ADDR_W  PRAM write address.
REQ-011 SHALL have port wr_data  output  DATA_W  PRAM write data.
REQ-012 SHALL have port wr_en  output  1  one-cycle PRAM write strobe.
REQ-013 SHALL have ports busy, done, error  output  1 each  status: load in progress, load-complete pulse, sticky failure.

Function
REQ-014 SHALL implement states IDLE, LEN_LO, LEN_HI, LOAD, CHK, FIN.
REQ-015 IDLE: start=1 -> LEN_LO, clear error and byte index; start ignored in every other state.
REQ-016 in_ready SHALL be 1 only in LEN_LO, LEN_HI, LOAD, CHK; busy=1 in every state except IDLE.
REQ-017 LEN_LO/LEN_HI: each transfer latches one byte of 16-bit length N (low first), advancing the state.
REQ-018 After LEN_HI transfer: N=0 -> FIN directly (CHK skipped, no writes); else LOAD.
REQ-019 LOAD: each transfer k (0..N-1) SHALL assert wr_en exactly one cycle after the transfer, with wr_addr=(BASE_ADDR+k) mod 2^ADDR_W and wr_data=in_data zero-extended/truncated to DATA_W.
REQ-020 Address SHALL wrap silently past 2^ADDR_W-1; N > 2^ADDR_W SHALL set error and go to FIN after the length is received.
REQ-021 Transfer N-1 SHALL move LOAD -> CHK (macro set) or FIN (macro clear); in_valid low simply stalls, no timeout.
REQ-022 FIN: done=1 for exactly one cycle, then IDLE; wr_addr/wr_data hold last written values.
REQ-023 Back-to-back transfers every cycle SHALL be supported with no bubbles; max wr_en rate one per cycle.

Reset
REQ-024 reset SHALL immediately force IDLE, in_ready=0, wr_en=0, busy=0, done=0, error=0, wr_addr=BASE_ADDR, wr_data=0, length and index=0.
REQ-025 reset mid-LOAD SHALL abort the load with no further wr_en; already-written PRAM contents are not restored.

Configuration
REQ-026 Macro PRAM_LOADER_CHECKSUM_EN defined: CHK accepts one byte; mismatch with 8-bit modular sum of all N data bytes sets error; FIN follows either way.
REQ-027 Macro undefined: no CHK state, no accumulator logic, error set only by REQ-020.

Structure
REQ-028 Shared package pram_pkg SHALL hold the state encoding typedef, default ADDR_W/DATA_W and PRAM depth constant, shared with PRAM.
REQ-029 Optional sub-module pram_loader_csum (8-bit accumulator, clear/add/compare); no other sub-modules.

Verification
REQ-030 start, bytes 03 00 AA BB CC (+checksum 31 if macro) -> wr_en at addr 0,1,2 with AA,BB,CC; done one pulse; error=0.
REQ-031 Macro set, bytes 02 00 10 20 checksum 00 -> writes 10,20 at 0,1; done pulse; error=1.
REQ-032 Length 00 00 -> no wr_en, no checksum byte consumed, done pulse two cycles after LEN_HI transfer.
REQ-033 BASE_ADDR=FFFE, N=3 -> writes at FFFE, FFFF, 0000.
REQ-034 reset asserted after 2nd data byte of N=5 -> outputs at reset values same cycle, no further wr_en, next start restarts cleanly.
REQ-035 in_valid toggled randomly and start pulsed while busy -> write sequence identical to continuous stream; start has no effect.
